// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte input, payload stream and status signals of the frame parser
interface uart_frame_parser_if;
  logic       uart_done;
  logic [7:0] uart_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  modport slave (
    input  uart_done, uart_data, out_ready,
    output out_valid, out_data, out_last, frame_ok, frame_err, err_code, overrun
  );

  modport master (
    output uart_done, uart_data, out_ready,
    input  out_valid, out_data, out_last, frame_ok, frame_err, err_code, overrun
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles 55 AA LEN PAYLOAD CHK frames and replays checked payloads
module uart_frame_parser #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000,
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  HDR0           = 8'h55,
  parameter logic [7:0]  HDR1           = 8'hAA
) (
  input logic                sys_clk,
  input logic                sys_rst,
  uart_frame_parser_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_SEND
  } state_t;

  state_t          state_q, state_d;
  logic            done_d;
  logic [LW-1:0]   len_q, len_d, idx_q, idx_d, rd_q, rd_d;
  logic [7:0]      chk_q, chk_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ok_d, err_d, ovr_d, wr_en;
  logic [1:0]      code_d;
  logic            frame_ok_q, frame_err_q, overrun_q;
  logic [1:0]      err_code_q;
  logic [7:0]      buf_mem [MAX_LEN];
  logic            accept;
  logic [7:0]      rx;
  logic            sending;

  // uart_done is a level, so only its rising edge counts as a new byte
  assign accept  = bus.uart_done & ~done_d;
  assign rx      = bus.uart_data;
  assign sending = (state_q == S_SEND);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    chk_d   = chk_q;
    timer_d = '0;
    wr_en   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    code_d  = err_code_q;
    unique case (state_q)
      S_IDLE: if (accept && rx == HDR0) state_d = S_HDR2;
      S_HDR2: if (accept) begin
        if (rx == HDR1)      state_d = S_LEN;
        else if (rx != HDR0) state_d = S_IDLE;
      end
      S_LEN: if (accept) begin
        if (rx == 8'd0 || rx > MAX_LEN_B) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'd1;
        end else begin
          len_d   = rx[LW-1:0];
          chk_d   = rx;
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (accept) begin
        wr_en = 1'b1;
        chk_d = chk_q + rx;
        idx_d = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = S_CHK;
      end
      S_CHK: if (accept) begin
        if (rx == chk_q) begin
          state_d = S_SEND;
          ok_d    = 1'b1;
          rd_d    = '0;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end
      end
      S_SEND: begin
        ovr_d = accept;
        if (bus.out_ready) begin
          if (rd_q == len_q - 1'b1) begin
            state_d = S_IDLE;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Inter-byte watchdog; an accepted byte in the same cycle takes precedence
    if ((state_q inside {S_HDR2, S_LEN, S_PAYLOAD, S_CHK}) && !accept) begin
      if (timer_q == TMAX) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        code_d  = 2'd3;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      done_d      <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      chk_q       <= '0;
      timer_q     <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      done_d      <= bus.uart_done;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      chk_q       <= chk_d;
      timer_q     <= timer_d;
      frame_ok_q  <= ok_d;
      frame_err_q <= err_d;
      overrun_q   <= ovr_d;
      err_code_q  <= code_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) buf_mem[idx_q[AW-1:0]] <= rx;
  end

  assign bus.out_valid = sending;
  assign bus.out_data  = sending ? buf_mem[rd_q[AW-1:0]] : 8'd0;
  assign bus.out_last  = sending && (rd_q == len_q - 1'b1);
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
  localparam int CLK_FREQ = 1_000_000;
  localparam int TO       = CLK_FREQ / 1000;
  localparam int MAX_LEN  = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int kind;
    int code;
  } ev_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  uart_frame_parser_if bus();

  uart_frame_parser #(
    .CLK_FREQ(CLK_FREQ), .TIMEOUT_CYCLES(TO), .MAX_LEN(MAX_LEN), .HDR0(8'h55), .HDR1(8'hAA)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   cyc = 0;
  ev_t  ev_q[$];
  logic [8:0] dq[$];
  int   hs_cyc[$];

  task automatic fail(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input int code);
    ev_t e;
    e.kind = kind;
    e.code = code;
    ev_q.push_back(e);
  endtask

  // Reference: a good frame yields frame_ok then every payload byte in order, last flagged
  task automatic expect_payload(input bq_t pl);
    push_ev(0, 0);
    foreach (pl[i]) dq.push_back({(i == pl.size() - 1) ? 1'b1 : 1'b0, pl[i]});
  endtask

  function automatic bq_t build_frame(input bq_t pl, input int chk_off);
    bq_t s;
    int  sum = pl.size();
    foreach (pl[i]) sum += int'(pl[i]);
    s.push_back(8'h55);
    s.push_back(8'hAA);
    s.push_back(8'(pl.size()));
    foreach (pl[i]) s.push_back(pl[i]);
    s.push_back(8'((sum + chk_off) % 256));
    return s;
  endfunction

  function automatic bq_t rand_pl(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge sys_clk); #1;
    bus.uart_data = b;
    bus.uart_done = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #1;
    bus.uart_done = 1'b0;
    bus.uart_data = 8'($urandom_range(0, 255));
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic send_seq(input bq_t s, input int hold);
    foreach (s[i]) send_byte(s[i], hold, $urandom_range(1, 3));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((ev_q.size() != 0 || dq.size() != 0 || bus.out_valid) && n < 5000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (n >= 5000) begin
      fail({name, "_drain_timeout"}, ev_q.size() + dq.size(), 0);
      ev_q.delete();
      dq.delete();
    end
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_out_valid"}, bus.out_valid, 0);
    chk({name, "_out_data"}, bus.out_data, 0);
    chk({name, "_out_last"}, bus.out_last, 0);
    chk({name, "_frame_ok"}, bus.frame_ok, 0);
    chk({name, "_frame_err"}, bus.frame_err, 0);
    chk({name, "_err_code"}, bus.err_code, 0);
    chk({name, "_overrun"}, bus.overrun, 0);
  endtask

  // Stream stimulus for out_ready
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT pulses or hands over a byte
  initial begin
    int         last_code = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;
    ev_t        e;
    logic [8:0] d;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst) begin
        last_code  = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (bus.frame_ok && bus.frame_err) fail("ok_err_same_cycle", 1, 0);
      if (bus.frame_ok || bus.frame_err || bus.overrun) begin
        if (ev_q.size() == 0) begin
          fail("unexpected_pulse", {bus.frame_ok, bus.frame_err, bus.overrun}, 0);
        end else begin
          e = ev_q.pop_front();
          chk("pulse_kind", bus.frame_err ? 1 : (bus.overrun ? 2 : 0), e.kind);
          if (e.kind == 1) begin
            chk("err_code", bus.err_code, e.code);
            last_code = e.code;
          end else begin
            chk("err_code_held", bus.err_code, last_code);
          end
        end
      end
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_word", {bus.out_last, bus.out_data}, prev_word);
      end
      if (bus.out_valid) begin
        if (dq.size() == 0) begin
          fail("unexpected_out_valid", bus.out_data, 0);
        end else if (bus.out_ready) begin
          d = dq.pop_front();
          chk("out_word", {bus.out_last, bus.out_data}, d);
          hs_cyc.push_back(cyc);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
    end
  end

  initial begin
    bq_t pl, s;
    int  kind, n_to;
    logic [7:0] junk;
    bus.uart_done = 1'b0;
    bus.uart_data = 8'h00;

    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);

    // Basic good frame with continuous ready
    ready_mode = 0;
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    s = build_frame(pl, 0);
    chk("ref_chk_byte", s[s.size() - 1], 8'h69);
    expect_payload(pl);
    send_seq(s, 1);
    wait_drain("good3");
    if (hs_cyc.size() >= 3) chk("consecutive_out", hs_cyc[hs_cyc.size() - 1] - hs_cyc[hs_cyc.size() - 3], 2);
    else fail("consecutive_out_count", hs_cyc.size(), 3);

    // Same frame with a bad checksum
    push_ev(1, 2);
    send_seq(build_frame(pl, 1), 1);
    wait_drain("bad_chk");

    // Zero and oversize lengths, then recovery
    push_ev(1, 1);
    s.delete(); s.push_back(8'h55); s.push_back(8'hAA); s.push_back(8'h00);
    send_seq(s, 1);
    wait_drain("len0");
    push_ev(1, 1);
    s.delete(); s.push_back(8'h55); s.push_back(8'hAA); s.push_back(8'(MAX_LEN + 1));
    send_seq(s, 1);
    wait_drain("len17");
    pl = rand_pl(MAX_LEN);
    expect_payload(pl);
    send_seq(build_frame(pl, 0), 1);
    wait_drain("len_max");

    // Header resync on repeated 0x55
    pl.delete(); pl.push_back(8'h7F);
    s = build_frame(pl, 0);
    s.push_front(8'h55);
    expect_payload(pl);
    send_seq(s, 1);
    wait_drain("resync");

    // Inter-byte timeout mid-payload
    push_ev(1, 3);
    s.delete(); s.push_back(8'h55); s.push_back(8'hAA); s.push_back(8'h02); s.push_back(8'h01);
    send_seq(s, 1);
    wait_drain("timeout");
    pl = rand_pl(2);
    expect_payload(pl);
    send_seq(build_frame(pl, 0), 1);
    wait_drain("after_timeout");

    // Stalled replay plus a byte during SEND
    ready_mode = 3;
    pl = rand_pl(4);
    expect_payload(pl);
    push_ev(2, 0);
    send_seq(build_frame(pl, 0), 1);
    send_byte(8'h12, 1, 4);
    chk("stalled_head", bus.out_data, pl[0]);
    ready_mode = 0;
    wait_drain("overrun");

    // Long uart_done level and toggling ready
    ready_mode = 1;
    pl = rand_pl(5);
    expect_payload(pl);
    send_seq(build_frame(pl, 0), 200);
    wait_drain("long_hold");

    // Reset mid-payload discards the frame silently
    ready_mode = 0;
    s.delete(); s.push_back(8'h55); s.push_back(8'hAA); s.push_back(8'h04); s.push_back(8'h01); s.push_back(8'h02);
    send_seq(s, 1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_idle_outputs("mid_reset");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    pl = rand_pl(3);
    expect_payload(pl);
    send_seq(build_frame(pl, 0), 1);
    wait_drain("after_reset");

    // Randomized mix of frames
    n_to = 0;
    for (int f = 0; f < 30; f++) begin
      ready_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h55) junk = 8'h54;
        send_byte(junk, $urandom_range(1, 3), $urandom_range(1, 3));
      end
      kind = $urandom_range(0, 9);
      if (kind == 9 && n_to >= 4) kind = 0;
      pl = rand_pl($urandom_range(1, MAX_LEN));
      if (kind <= 5) begin
        expect_payload(pl);
        send_seq(build_frame(pl, 0), $urandom_range(1, 3));
      end else if (kind <= 7) begin
        push_ev(1, 2);
        send_seq(build_frame(pl, $urandom_range(1, 255)), 1);
      end else if (kind == 8) begin
        push_ev(1, 1);
        s.delete(); s.push_back(8'h55); s.push_back(8'hAA);
        s.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        send_seq(s, 1);
      end else begin
        n_to++;
        push_ev(1, 3);
        s = build_frame(pl, 0);
        s = s[0:$urandom_range(0, s.size() - 2)];
        send_seq(s, 1);
      end
      wait_drain("random");
    end

    chk("events_left", ev_q.size(), 0);
    chk("bytes_left", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
